// File: rtl/lsu_pkg.sv
// Shared constants, request record and alignment check for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } lsu_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction (with sign/zero extension) and sub-word merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sgn,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rd_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: ext_data = {{24{sgn & sel_byte[7]}}, sel_byte};
            SZ_HALF: ext_data = {{16{sgn & sel_half[15]}}, sel_half};
            default: ext_data = rd_word;
        endcase
    end

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only RAM; sub-word stores are read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_write_en,
    output logic [5:0]        ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    lsu_state_t  state;
    lsu_req_t    req_q;
    logic [31:0] merge_buf;
    logic [31:0] ext_data;
    logic [31:0] merged;
    logic        req_err;

    assign req_err = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);

    // RAM-facing outputs come only from registers or state decode.
    assign req_ready    = (state == ST_IDLE);
    assign resp_valid   = (state == ST_RESP);
    assign ram_write_en = (state == ST_WRITE);
    assign ram_wdata    = ram_write_en ? merged : 32'd0;

    lsu_lane_align u_align (
        .rd_word  (ram_rdata),
        .size     (req_q.size),
        .addr_lo  (req_q.addr_lo),
        .sgn      (req_q.sgn),
        .old_word (merge_buf),
        .wdata    (req_q.wdata),
        .ext_data (ext_data),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            merge_buf  <= '0;
            ram_addr   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q      <= '{write: req_write, size: req_size, sgn: req_signed,
                                        addr_lo: req_addr[1:0], wdata: req_wdata};
                        ram_addr   <= req_addr[ADDR_W-1:2];
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        if (req_err)
                            state <= ST_RESP;
                        else if (req_write && req_size == SZ_WORD)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (req_q.write) begin
                        merge_buf <= ram_rdata;
                        state     <= ST_WRITE;
                    end else begin
                        resp_rdata <= ext_data;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                default: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM model, transaction-level reference model, per-cycle compare.
module tb_load_store_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        ram_write_en;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    always @(posedge clk) if (ram_write_en) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = ram_write_en ? 32'd0 : mem[ram_addr];

    int total = 0;
    int bad   = 0;

    bit          active = 1'b0;
    int          cyc = 0;
    int          exp_lat;
    bit          exp_err, exp_wr;
    logic [31:0] exp_rdata, exp_wword;
    logic [5:0]  exp_idx;
    logic [31:0] got_rdata;
    logic        got_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: what one request must produce, from the access rules alone.
    task automatic model(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] word, v, mask;
        int lo;
        lo        = int'(addr[1:0]);
        exp_idx   = addr[7:2];
        word      = ref_mem[exp_idx];
        exp_rdata = 32'd0;
        exp_wr    = 1'b0;
        exp_err   = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b00 && lo != 0);
        if (exp_err) begin
            exp_lat = 1;
        end else if (!w) begin
            exp_lat = 2;
            if (sz == 2'b10) begin
                v = (word >> (8 * lo)) & 32'hFF;
                if (sg && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                v = (word >> (8 * lo)) & 32'hFFFF;
                if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
            exp_rdata = v;
        end else begin
            exp_wr = 1'b1;
            if (sz == 2'b00) begin
                exp_lat   = 2;
                exp_wword = wd;
            end else begin
                exp_lat   = 3;
                mask      = ((sz == 2'b10) ? 32'hFF : 32'hFFFF) << (8 * lo);
                exp_wword = (word & ~mask) | ((wd << (8 * lo)) & mask);
            end
            ref_mem[exp_idx] = exp_wword;
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            cyc++;
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("ram_addr", 32'(ram_addr), 32'(exp_idx));
            chk("ram_write_en", 32'(ram_write_en), 32'(exp_wr && cyc == exp_lat - 1));
            chk("ram_wdata", ram_wdata, (exp_wr && cyc == exp_lat - 1) ? exp_wword : 32'd0);
            chk("resp_valid", 32'(resp_valid), 32'(cyc >= exp_lat));
            if (cyc >= exp_lat) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
            end
        end else if (!rst) begin
            chk("idle_write_en", 32'(ram_write_en), 32'd0);
            chk("idle_wdata", ram_wdata, 32'd0);
        end
    end

    task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [7:0] addr, input logic [31:0] wd,
                          input int hold, input bit rst_in_write);
        int n;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd;
        model(w, sz, sg, addr, wd);
        @(posedge clk);
        #1;
        active = 1'b1;
        cyc    = 0;
        // Junk request held during the busy period must be ignored.
        req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
        got_rdata = 32'hx; got_err = 1'bx;
        if (rst_in_write) begin
            n = 0;
            while (!ram_write_en && n < 10) begin @(posedge clk); #1; n++; end
            @(negedge clk); #1;
            rst = 1'b1; active = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0; req_valid = 1'b0;
            chk("rst_write_en", 32'(ram_write_en), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
            chk("rst_ram_addr", 32'(ram_addr), 32'd0);
            chk("rst_mem", mem[exp_idx], ref_mem[exp_idx]);
            return;
        end
        n = 0;
        while (!resp_valid && n < 10) begin @(negedge clk); n++; end
        if (!resp_valid) begin
            total++; bad++;
            $display("FAIL resp_timeout act=%0d req=%0d", n, exp_lat);
            active = 1'b0; req_valid = 1'b0;
            return;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        repeat (hold) @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        active     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 8'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_write_en", 32'(ram_write_en), 32'd0);
        chk("reset_ram_addr", 32'(ram_addr), 32'd0);
        chk("reset_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;

        do_req(1, 2'b00, 0, 8'h10, 32'hDEADBEEF, 0, 0);
        chk("sw_err", 32'(got_err), 32'd0);
        do_req(0, 2'b00, 0, 8'h10, 32'd0, 0, 0);
        chk("lw_deadbeef", got_rdata, 32'hDEADBEEF);

        do_req(1, 2'b00, 0, 8'h10, 32'h11223344, 0, 0);
        do_req(1, 2'b10, 0, 8'h12, 32'hFFFFFFAB, 1, 0);
        do_req(0, 2'b00, 0, 8'h10, 32'd0, 0, 0);
        chk("sb_merge", got_rdata, 32'h11AB3344);

        do_req(1, 2'b00, 0, 8'h10, 32'h80FF7F01, 0, 0);
        do_req(0, 2'b10, 1, 8'h11, 32'd0, 0, 0);
        chk("lb_s_11", got_rdata, 32'h0000007F);
        do_req(0, 2'b10, 1, 8'h12, 32'd0, 0, 0);
        chk("lb_s_12", got_rdata, 32'hFFFFFFFF);
        do_req(0, 2'b01, 0, 8'h12, 32'd0, 0, 0);
        chk("lh_u_12", got_rdata, 32'h000080FF);
        do_req(0, 2'b01, 1, 8'h12, 32'd0, 0, 0);
        chk("lh_s_12", got_rdata, 32'hFFFF80FF);

        do_req(0, 2'b00, 0, 8'h13, 32'd0, 0, 0);
        chk("err_lw_13", 32'(got_err), 32'd1);
        do_req(1, 2'b01, 0, 8'h11, 32'h1234, 0, 0);
        chk("err_sh_11", 32'(got_err), 32'd1);
        do_req(1, 2'b11, 0, 8'h10, 32'h5555, 0, 0);
        chk("err_rsvd", 32'(got_err), 32'd1);
        chk("err_rsvd_rdata", got_rdata, 32'd0);

        do_req(0, 2'b00, 0, 8'h10, 32'd0, 5, 0);
        chk("bp_rdata", got_rdata, 32'h80FF7F01);
        do_req(0, 2'b10, 0, 8'h13, 32'd0, 0, 0);
        chk("bp_next", got_rdata, 32'h00000080);

        do_req(1, 2'b10, 0, 8'h13, 32'h0000005A, 0, 1);
        do_req(0, 2'b00, 0, 8'h10, 32'd0, 0, 0);
        chk("rst_write_kept", got_rdata, 32'h5AFF7F01);

        for (int i = 0; i < 200; i++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom_range(0, 63)),
                   $urandom, $urandom_range(0, 3), 0);

        @(negedge clk);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
